mem_initiator: RTL and testbench
================================

MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the data and instruction word width.
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the memory word-address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port if_req, input, 1 bit: core requests an instruction fetch.
REQ-006 The block SHALL have port if_addr, input, ADDR_W bits: fetch address.
REQ-007 The block SHALL have port if_flush, input, 1 bit: cancel all in-flight fetches.
REQ-008 The block SHALL have port if_valid, output, 1 bit: if_data holds a fetched word this cycle.
REQ-009 The block SHALL have port if_data, output, DATA_W bits: fetched instruction word.
REQ-010 The block SHALL have port dm_req, input, 1 bit: core requests a data access.
REQ-011 The block SHALL have port dm_we, input, 1 bit: 1 = write, 0 = read; qualified by dm_req.
REQ-012 The block SHALL have port dm_addr, input, ADDR_W bits: data address.
REQ-013 The block SHALL have port dm_wdata, input, DATA_W bits: write data.
REQ-014 The block SHALL have port dm_ready, output, 1 bit: data request accepted when dm_req and dm_ready are both 1 at a rising edge.
REQ-015 The block SHALL have port dm_rvalid, output, 1 bit: one-cycle pulse marking dm_rdata valid.
REQ-016 The block SHALL have port dm_rdata, output, DATA_W bits: read data.
REQ-017 The block SHALL have port mem_i_addr, output, ADDR_W bits: memory instruction address.
REQ-018 The block SHALL have port mem_i_bus, input, DATA_W bits: memory instruction data, registered in memory, valid one cycle after mem_i_addr is presented.
REQ-019 The block SHALL have port mem_d_addr, output, ADDR_W bits: memory data address.
REQ-020 The block SHALL have port mem_read, output, 1 bit: memory drives mem_d_bus while high, with the word at the mem_d_addr of the previous cycle.
REQ-021 The block SHALL have port mem_write, output, 1 bit: memory writes mem_d_bus to mem_d_addr at the rising edge.
REQ-022 The block SHALL have port mem_d_bus, inout, DATA_W bits: shared bidirectional data bus.

Function
REQ-023 Fetch SHALL be a 2-stage pipeline accepting one request per cycle, with no backpressure.
REQ-024 An accepted fetch SHALL follow this timing: on acceptance at edge E0, mem_i_addr = if_addr from E0 through E1; mem_i_bus is sampled into if_data at E2; if_valid = 1 for the cycle after E2.
REQ-025 In a cycle with no new fetch, mem_i_addr SHALL hold its last value.
REQ-026 When if_flush = 1 at an edge, the valid bits of all in-flight fetches SHALL be cleared, and a fetch accepted at that same edge SHALL proceed normally.
REQ-027 The data FSM SHALL have states IDLE, RD_ADDR, RD_DATA and WR.
REQ-028 dm_ready SHALL be 1 only in IDLE.
REQ-029 From IDLE, an accepted read SHALL go to RD_ADDR, with dm_addr registered onto mem_d_addr.
REQ-030 RD_ADDR SHALL keep mem_read = 0 and go to RD_DATA.
REQ-031 RD_DATA SHALL assert mem_read = 1, hold mem_d_addr, capture mem_d_bus into dm_rdata at the edge, and go to IDLE with dm_rvalid = 1 for one cycle.
REQ-032 From IDLE, an accepted write SHALL go to WR.
REQ-033 WR SHALL assert mem_write = 1, drive the registered address on mem_d_addr and the registered data on mem_d_bus for exactly one cycle, then go to IDLE; dm_rvalid SHALL stay 0.
REQ-034 Read latency SHALL be: acceptance at E0, data captured at E2, dm_rvalid high for the cycle after E2; the next request is accepted no earlier than E2.
REQ-035 The block SHALL drive mem_d_bus only in WR and SHALL present high-impedance otherwise.
REQ-036 mem_read and mem_write SHALL never both be 1.
REQ-037 A read following a write to the same address SHALL return the newly written value.
REQ-038 The fetch and data paths SHALL be independent; simultaneous activity on both SHALL be legal.
REQ-039 Addresses SHALL pass unmodified, with no range check.
REQ-040 dm_rdata SHALL hold its value until the next read completes.

Reset
REQ-041 While rst_n = 0, the block SHALL hold the FSM in IDLE and set if_valid, dm_rvalid, mem_read and mem_write to 0.
REQ-042 While rst_n = 0, the block SHALL set mem_i_addr, mem_d_addr, if_data and dm_rdata to 0 and mem_d_bus to Z.
REQ-043 A reset asserted mid-operation SHALL discard all in-flight fetches and data accesses with no valid pulse.
REQ-044 dm_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-045 A bench SHALL cover fetches at 0x10, 0x11, 0x12 on consecutive cycles -> if_valid on 3 consecutive cycles, with if_data = mem[0x10], mem[0x11], mem[0x12], the first 2 cycles after acceptance.
REQ-046 A bench SHALL cover a write of 0xBEEF to 0x20 followed by a read of 0x20 -> mem_write for one cycle with bus = 0xBEEF; the read returns dm_rdata = 0xBEEF with dm_rvalid for exactly one cycle.
REQ-047 A bench SHALL cover if_flush one cycle after 2 back-to-back fetches -> no if_valid for either; a fetch accepted at the flush edge -> if_valid 2 cycles later.
REQ-048 A bench SHALL cover rst_n pulled low in RD_DATA -> no dm_rvalid, mem_read = 0, bus = Z, and dm_ready = 1 after release.
REQ-049 A bench SHALL cover dm_req held high with alternating read and write -> dm_ready low in RD_ADDR, RD_DATA and WR, and mem_read and mem_write never high together.
REQ-050 A bench SHALL cover a concurrent fetch of 0x15 with a read of 0x30 -> both complete with correct data and unchanged latencies.

Source files
------------

// File: rtl/mem_initiator.sv
// Memory initiator: a 2-stage instruction-fetch pipeline plus a data-port FSM
// that shares one bidirectional bus for reads and writes.
module mem_initiator #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  // memory side
  output logic [ADDR_W-1:0] mem_i_addr,
  input  logic [DATA_W-1:0] mem_i_bus,
  output logic [ADDR_W-1:0] mem_d_addr,
  output logic              mem_read,
  output logic              mem_write,
  inout  wire  [DATA_W-1:0] mem_d_bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Fetch pipeline
  // ---------------------------------------------------------------------------
  logic              r_f1_valid;
  logic              r_f2_valid;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_if_data;
  logic [ADDR_W-1:0] r_mem_i_addr;
  logic              w_f2_keep;

  // A flush kills everything already in flight, but not the fetch accepted at the same edge.
  assign w_f2_keep = r_f2_valid & ~if_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f1_valid   <= 1'b0;
      r_f2_valid   <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_data    <= '0;
      r_mem_i_addr <= '0;
    end else begin
      r_f1_valid <= if_req;
      r_f2_valid <= r_f1_valid & ~if_flush;
      r_if_valid <= w_f2_keep;
      if (if_req) begin
        r_mem_i_addr <= if_addr;
      end
      if (w_f2_keep) begin
        r_if_data <= mem_i_bus;
      end
    end
  end

  assign if_valid   = r_if_valid;
  assign if_data    = r_if_data;
  assign mem_i_addr = r_mem_i_addr;

  // ---------------------------------------------------------------------------
  // Data FSM
  // ---------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_next;
  logic              w_ready;
  logic              w_accept;
  logic              w_mem_read;
  logic              w_mem_write;
  logic [ADDR_W-1:0] r_mem_d_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_dm_rvalid;
  logic [DATA_W-1:0] r_dm_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_accept     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (dm_req) begin
          w_accept     = 1'b1;
          w_state_next = dm_we ? WR : RD_ADDR;
        end
      end
      // Address settles for one cycle so the registered memory can look it up.
      RD_ADDR: w_state_next = RD_DATA;
      RD_DATA: begin
        w_mem_read   = 1'b1;
        w_state_next = IDLE;
      end
      WR: begin
        w_mem_write  = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_d_addr <= '0;
      r_wdata      <= '0;
      r_dm_rvalid  <= 1'b0;
      r_dm_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_mem_d_addr <= dm_addr;
        if (dm_we) begin
          r_wdata <= dm_wdata;
        end
      end
      r_dm_rvalid <= w_mem_read;
      if (w_mem_read) begin
        r_dm_rdata <= mem_d_bus;
      end
    end
  end

  assign dm_ready   = w_ready;
  assign dm_rvalid  = r_dm_rvalid;
  assign dm_rdata   = r_dm_rdata;
  assign mem_d_addr = r_mem_d_addr;
  assign mem_read   = w_mem_read;
  assign mem_write  = w_mem_write;
  assign mem_d_bus  = w_mem_write ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: memory models, an edge-indexed reference model with a
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush;
  logic [15:0] if_addr;
  logic        if_valid;
  logic [15:0] if_data;
  logic        dm_req, dm_we;
  logic [15:0] dm_addr, dm_wdata;
  logic        dm_ready, dm_rvalid;
  logic [15:0] dm_rdata;
  logic [15:0] mem_i_addr, mem_i_bus, mem_d_addr;
  logic        mem_read, mem_write;
  wire  [15:0] mem_d_bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // An undriven bus floats high, so high-impedance shows up as 16'hFFFF.
  pullup (mem_d_bus);

  mem_initiator #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_data(if_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_i_addr(mem_i_addr), .mem_i_bus(mem_i_bus),
    .mem_d_addr(mem_d_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_d_bus(mem_d_bus)
  );

  function automatic logic [15:0] imem_val(input logic [15:0] a);
    return {8'hA5, a[7:0]};
  endfunction

  function automatic logic [15:0] dmem_init(input logic [15:0] a);
    return {8'h50, a[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] r_dbus;

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = imem_val(16'(i));
      dmem[i] = dmem_init(16'(i));
    end
  end

  always @(posedge clk) begin
    mem_i_bus <= imem[mem_i_addr[7:0]];
    r_dbus    <= dmem[mem_d_addr[7:0]];
    if (mem_write) dmem[mem_d_addr[7:0]] <= mem_d_bus;
  end

  assign mem_d_bus = mem_read ? r_dbus : 16'hzzzz;

  // ---------------- reference model + compare ----------------
  int          k = 0;
  bit          m_sv [4];
  logic [15:0] m_sd [4];
  logic [15:0] m_ref [256];
  logic [15:0] m_iaddr, m_daddr, m_rd_addr, m_wr_data, m_rdata, e_ifd;
  int          m_free, m_rd_edge, m_wr_edge;
  bit          e_ifv, e_rvalid, e_read, e_write, e_ready;

  initial begin
    for (int i = 0; i < 256; i++) m_ref[i] = dmem_init(16'(i));
  end

  always @(posedge clk) begin
    k++;
    e_rvalid = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_sv[i] = 1'b0;
      e_ifv = 1'b0; e_ifd = '0;
      m_iaddr = '0; m_daddr = '0; m_rdata = '0;
      m_free = k; m_rd_edge = -100; m_wr_edge = -100;
    end else begin
      if (if_flush) begin
        m_sv[2'(k)] = 1'b0;
        m_sv[2'(k+1)] = 1'b0;
      end
      if (if_req) begin
        m_sv[2'(k+2)] = 1'b1;
        m_sd[2'(k+2)] = imem_val(if_addr);
        m_iaddr = if_addr;
      end
      e_ifv = m_sv[2'(k)];
      e_ifd = m_sd[2'(k)];
      m_sv[2'(k)] = 1'b0;
      if (dm_req && (k - 1 >= m_free)) begin
        m_daddr = dm_addr;
        if (dm_we) begin
          m_wr_edge = k; m_wr_data = dm_wdata;
          m_ref[dm_addr[7:0]] = dm_wdata;
          m_free = k + 1;
        end else begin
          m_rd_edge = k; m_rd_addr = dm_addr;
          m_free = k + 2;
        end
      end
      if (m_rd_edge == k - 2) begin
        e_rvalid = 1'b1;
        m_rdata = m_ref[m_rd_addr[7:0]];
      end
    end
    e_read  = rst_n && (m_rd_edge == k - 1);
    e_write = rst_n && (m_wr_edge == k);
    e_ready = (k >= m_free);
    #1;
    chk("if_valid", 32'(if_valid), 32'(e_ifv));
    if (e_ifv || !rst_n) chk("if_data", 32'(if_data), 32'(e_ifd));
    chk("mem_i_addr", 32'(mem_i_addr), 32'(m_iaddr));
    chk("dm_ready", 32'(dm_ready), 32'(e_ready));
    chk("mem_read", 32'(mem_read), 32'(e_read));
    chk("mem_write", 32'(mem_write), 32'(e_write));
    chk("rw_excl", 32'(mem_read & mem_write), 32'(0));
    chk("mem_d_addr", 32'(mem_d_addr), 32'(m_daddr));
    chk("dm_rvalid", 32'(dm_rvalid), 32'(e_rvalid));
    chk("dm_rdata", 32'(dm_rdata), 32'(m_rdata));
    if (e_write) chk("bus_wdata", 32'(mem_d_bus), 32'(m_wr_data));
    else if (!e_read) chk("bus_z", 32'(mem_d_bus), 32'(16'hFFFF));
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ready();
    int n = 0;
    while (!dm_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(dm_ready), 32'(1));
  endtask

  initial begin
    logic nxt_we;
    int   idx;
    rst_n = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_if_valid", 32'(if_valid), 32'(0));
    chk("rst_rvalid", 32'(dm_rvalid), 32'(0));
    chk("rst_mem_read", 32'(mem_read), 32'(0));
    chk("rst_mem_write", 32'(mem_write), 32'(0));
    chk("rst_iaddr", 32'(mem_i_addr), 32'(0));
    chk("rst_daddr", 32'(mem_d_addr), 32'(0));
    chk("rst_if_data", 32'(if_data), 32'(0));
    chk("rst_rdata", 32'(dm_rdata), 32'(0));
    chk("rst_bus_z", 32'(mem_d_bus), 32'(16'hFFFF));
    rst_n = 1'b1;
    chk("rel_ready", 32'(dm_ready), 32'(1));

    // Three back-to-back fetches.
    @(negedge clk); if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk); if_addr = 16'h0011;
    @(negedge clk); if_addr = 16'h0012;
    @(negedge clk); if_req = 1'b0;
    chk("f10_v", 32'(if_valid), 32'(1)); chk("f10_d", 32'(if_data), 32'(16'hA510));
    @(negedge clk);
    chk("f11_v", 32'(if_valid), 32'(1)); chk("f11_d", 32'(if_data), 32'(16'hA511));
    @(negedge clk);
    chk("f12_v", 32'(if_valid), 32'(1)); chk("f12_d", 32'(if_data), 32'(16'hA512));
    @(negedge clk);
    chk("f_end_v", 32'(if_valid), 32'(0));
    $display("txn fetch 0x10-0x12 done");

    // Write 0xBEEF to 0x20, then read it back.
    @(negedge clk); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'hBEEF;
    @(negedge clk); dm_req = 1'b0;
    chk("wr_mem_write", 32'(mem_write), 32'(1));
    chk("wr_bus", 32'(mem_d_bus), 32'(16'hBEEF));
    chk("wr_addr", 32'(mem_d_addr), 32'(16'h0020));
    @(negedge clk);
    chk("wr_one_cycle", 32'(mem_write), 32'(0));
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0020;
    @(negedge clk); dm_req = 1'b0;
    chk("rdaddr_ready", 32'(dm_ready), 32'(0));
    chk("rdaddr_read", 32'(mem_read), 32'(0));
    @(negedge clk);
    chk("rddata_read", 32'(mem_read), 32'(1));
    @(negedge clk);
    chk("rd_rvalid", 32'(dm_rvalid), 32'(1)); chk("rd_beef", 32'(dm_rdata), 32'(16'hBEEF));
    @(negedge clk);
    chk("rd_pulse", 32'(dm_rvalid), 32'(0)); chk("rd_hold", 32'(dm_rdata), 32'(16'hBEEF));
    $display("txn write/read 0x20 done");

    // Flush one cycle after two fetches, with a fetch accepted at the flush edge.
    @(negedge clk); if_req = 1'b1; if_addr = 16'h0050;
    @(negedge clk); if_addr = 16'h0051;
    @(negedge clk); if_flush = 1'b1; if_addr = 16'h0052;
    @(negedge clk); if_flush = 1'b0; if_req = 1'b0;
    chk("fl_a_killed", 32'(if_valid), 32'(0));
    @(negedge clk);
    chk("fl_b_killed", 32'(if_valid), 32'(0));
    @(negedge clk);
    chk("fl_new_v", 32'(if_valid), 32'(1)); chk("fl_new_d", 32'(if_data), 32'(16'hA552));
    $display("txn flush done");

    // Reset asserted while in RD_DATA.
    @(negedge clk); wait_ready(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0021;
    @(negedge clk); dm_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_read", 32'(mem_read), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_read_off", 32'(mem_read), 32'(0));
    chk("rst_no_rvalid", 32'(dm_rvalid), 32'(0));
    chk("rst_bus_float", 32'(mem_d_bus), 32'(16'hFFFF));
    @(negedge clk);
    chk("rst_no_rvalid2", 32'(dm_rvalid), 32'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(dm_ready), 32'(1));
    @(negedge clk);
    chk("post_rst_rvalid", 32'(dm_rvalid), 32'(0));
    $display("txn reset in RD_DATA done");

    // dm_req held high, alternating write and read.
    @(negedge clk); wait_ready();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h3C00;
    nxt_we = 1'b0; idx = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (dm_ready) begin
        dm_we = nxt_we; dm_addr = 16'h0040 + 16'(idx); dm_wdata = 16'h3C00 + 16'(idx);
        if (!nxt_we) idx++;
        nxt_we = ~nxt_we;
      end
    end
    dm_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("txn alternating rd/wr done");

    // Concurrent fetch and read.
    wait_ready();
    if_req = 1'b1; if_addr = 16'h0015;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0030;
    @(negedge clk); if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("cc_if_v", 32'(if_valid), 32'(1)); chk("cc_if_d", 32'(if_data), 32'(16'hA515));
    chk("cc_rvalid", 32'(dm_rvalid), 32'(1)); chk("cc_rdata", 32'(dm_rdata), 32'(16'h5030));
    $display("txn concurrent fetch/read done");

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
